// File: rtl/cdc_event_scheduler_pkg.sv
// Package: cdc_event_sched_pkg
// Shared types and helpers for the CDC event scheduler.
//   sched_state_t : issue FSM states (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH)
//   idWidth(n)    : width of a requester index for n requesters; never below 1
//                   so that a degenerate count still yields a legal vector.
package cdc_event_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } sched_state_t;

  function automatic int idWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_event_scheduler_rr_pick.sv
// Module: cdc_event_rr_pick
// Combinational winner selection among requesters with pending events.
// Optional feature macro: CDC_EVENT_SCHED_FIXED_PRIO_EN
//   undefined : round-robin, first valid index scanning upward from pointer+1
//               with wrap-around.
//   defined   : fixed priority, lowest valid index wins; no pointer input.
// Ports:
//   valid    in   N_REQ   bit i set when requester i has a pending event
//   pointer  in   ID_W    last granted index (round-robin build only)
//   winner   out  ID_W    selected index (0 when nothing is valid)
//   anyValid out  1       at least one valid bit set
module cdc_event_rr_pick
  import cdc_event_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = idWidth(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
`ifndef CDC_EVENT_SCHED_FIXED_PRIO_EN
  input  logic [ID_W-1:0]  pointer,
`endif
  output logic [ID_W-1:0]  winner,
  output logic             anyValid
);

  logic found;

  assign anyValid = |valid;

`ifdef CDC_EVENT_SCHED_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && valid[j]) begin
        winner = ID_W'(j);
        found  = 1'b1;
      end
    end
  end
`else
  // Two passes: indices strictly above the pointer first, then wrap to the
  // lowest valid index (which is necessarily at or below the pointer).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && valid[j] && (ID_W'(j) > pointer)) begin
        winner = ID_W'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && valid[j]) begin
        winner = ID_W'(j);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdc_event_scheduler.sv
// Module: cdc_event_scheduler
// Source-side scheduler that shares one CDC event channel among N_REQ
// requesters. Each requester has a saturating pending-event counter; events
// are issued one at a time as single-cycle pulses on evtRequest_o, tagged by
// grantId_o, and only after the channel has completed its ready low/high
// handshake for the previous event.
// Optional feature macro: CDC_EVENT_SCHED_FIXED_PRIO_EN (fixed priority pick,
// no round-robin pointer). Ports and timing are identical in both builds.
// Ports:
//   clk_i        in   1      source clock, rising edge
//   rst_i        in   1      synchronous active-high reset
//   req_i        in   N_REQ  one-cycle event pulses, any combination
//   evtRequest_o out  1      one-cycle request to the CDC event channel
//   evtReady_i   in   1      channel ready
//   grantId_o    out  ID     index of the current/last issue, held until next
//   pending_o    out  N_REQ  bit i = counter i nonzero
//   overflow_o   out  N_REQ  pulse: event dropped on a saturated counter
module cdc_event_scheduler
  import cdc_event_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic                     evtRequest_o,
  input  logic                     evtReady_i,
  output logic [$clog2(N_REQ)-1:0] grantId_o,
  output logic [N_REQ-1:0]         pending_o,
  output logic [N_REQ-1:0]         overflow_o
);

  localparam int              ID_W    = idWidth(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t     stateReg, stateNext;
  logic [CNT_W-1:0] cntReg  [N_REQ];
  logic [CNT_W-1:0] cntNext [N_REQ];
  logic [N_REQ-1:0] overflowReg, overflowNext;
  logic [N_REQ-1:0] cntNonZero;
  logic [N_REQ-1:0] issueHit;
  logic             evtRequestReg;
  logic [ID_W-1:0]  grantIdReg;
  logic [ID_W-1:0]  winner;
  logic             anyValid;
  logic             issueNow;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign cntNonZero[gi] = |cntReg[gi];
      assign issueHit[gi]   = issueNow && (winner == ID_W'(gi));
    end
  endgenerate

`ifdef CDC_EVENT_SCHED_FIXED_PRIO_EN
  cdc_event_rr_pick #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid   (cntNonZero),
    .winner  (winner),
    .anyValid(anyValid)
  );
`else
  logic [ID_W-1:0] rrPtrReg;

  cdc_event_rr_pick #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid   (cntNonZero),
    .pointer (rrPtrReg),
    .winner  (winner),
    .anyValid(anyValid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtrReg <= ID_W'(N_REQ - 1);
    end else if (issueNow) begin
      rrPtrReg <= winner;
    end
  end
`endif

  // Issue FSM. The issue decision is taken in IDLE and becomes visible one
  // cycle later (ISSUE), together with the decremented counter.
  always_comb begin
    stateNext = stateReg;
    issueNow  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (evtReady_i && anyValid) begin
          issueNow  = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE:     stateNext = WAIT_LOW;
      WAIT_LOW:  if (!evtReady_i) stateNext = WAIT_HIGH;
      WAIT_HIGH: if (evtReady_i)  stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // A request and an issue on the same counter cancel out, so a saturated
  // counter only drops an event when it is not being drained that cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cntNext[i]      = cntReg[i];
      overflowNext[i] = 1'b0;
      if (req_i[i] && !issueHit[i]) begin
        if (cntReg[i] == CNT_MAX) begin
          overflowNext[i] = 1'b1;
        end else begin
          cntNext[i] = cntReg[i] + 1'b1;
        end
      end else if (!req_i[i] && issueHit[i]) begin
        cntNext[i] = cntReg[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg      <= IDLE;
      evtRequestReg <= 1'b0;
      grantIdReg    <= '0;
      overflowReg   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cntReg[i] <= '0;
      end
    end else begin
      stateReg      <= stateNext;
      evtRequestReg <= issueNow;
      overflowReg   <= overflowNext;
      if (issueNow) begin
        grantIdReg <= winner;
      end
      for (int i = 0; i < N_REQ; i++) begin
        cntReg[i] <= cntNext[i];
      end
    end
  end

  assign evtRequest_o = evtRequestReg;
  assign grantId_o    = grantIdReg;
  assign pending_o    = cntNonZero;
  assign overflow_o   = overflowReg;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Testbench for cdc_event_scheduler (N_REQ=4, CNT_W=4). Directed scenarios
// followed by a randomized phase; every cycle the outputs are compared with a
// behavioural model built from the event-counting and handshake rules.
module tb_cdc_event_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [N_REQ-1:0] req_i = '0;
  logic             evtReady_i = 1'b1;
  logic             evtRequest_o;
  logic [1:0]       grantId_o;
  logic [N_REQ-1:0] pending_o;
  logic [N_REQ-1:0] overflow_o;

  cdc_event_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .evtRequest_o(evtRequest_o),
    .evtReady_i  (evtReady_i),
    .grantId_o   (grantId_o),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: event counts, last winner, handshake phase.
  // Phase 0: free to issue; 1: request on the wire; 2: waiting for the
  // channel to drop ready; 3: waiting for ready to come back.
  int               mCnt [N_REQ];
  int               mLast;
  int               mGrant;
  int               mPhase;
  bit               mReq;
  logic [N_REQ-1:0] mOvf;

  // Channel model and logs.
  bit autoChan = 1'b0;
  int lowLeft  = 0;
  int issueLog [$];
  int issueCyc [$];
  int ovf3Count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pickWinner();
`ifdef CDC_EVENT_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) if (mCnt[k] > 0) return k;
`else
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (mLast + k) % N_REQ;
      if (mCnt[idx] > 0) return idx;
    end
`endif
    return 0;
  endfunction

  task automatic modelStep(input logic [N_REQ-1:0] req, input logic rdy, input logic rst);
    bit anyP;
    bit issue;
    int w;
    int c;
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) mCnt[i] = 0;
      mLast = N_REQ - 1; mGrant = 0; mPhase = 0; mReq = 0; mOvf = '0;
      return;
    end
    anyP = 0;
    for (int i = 0; i < N_REQ; i++) if (mCnt[i] > 0) anyP = 1;
    issue = (mPhase == 0) && rdy && anyP;
    w = issue ? pickWinner() : 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = mCnt[i] + (req[i] ? 1 : 0) - ((issue && w == i) ? 1 : 0);
      mOvf[i] = (c > CMAX);
      mCnt[i] = (c > CMAX) ? CMAX : c;
    end
    case (mPhase)
      0: mPhase = issue ? 1 : 0;
      1: mPhase = 2;
      2: mPhase = rdy ? 2 : 3;
      default: mPhase = rdy ? 0 : 3;
    endcase
    mReq = issue;
    if (issue) begin
      mGrant = w;
      mLast  = w;
    end
  endtask

  function automatic logic [N_REQ-1:0] modelPending();
    logic [N_REQ-1:0] p;
    for (int i = 0; i < N_REQ; i++) p[i] = (mCnt[i] > 0);
    return p;
  endfunction

  // One clock: model advances with the inputs the DUT sampled, outputs are
  // compared 1 time unit after the edge, then next-cycle inputs are prepared.
  task automatic tick();
    @(posedge clk_i);
    modelStep(req_i, evtReady_i, rst_i);
    #1;
    cyc++;
    check("evtRequest", 32'(evtRequest_o), 32'(mReq));
    check("grantId",    32'(grantId_o),    32'(mGrant));
    check("pending",    32'(pending_o),    32'(modelPending()));
    check("overflow",   32'(overflow_o),   32'(mOvf));
    if (evtRequest_o === 1'b1) begin
      issueLog.push_back(int'(grantId_o));
      issueCyc.push_back(cyc);
    end
    if (overflow_o[3] === 1'b1) ovf3Count++;
    req_i = '0;
    if (autoChan) begin
      if (lowLeft > 0) begin
        evtReady_i = 1'b0;
        lowLeft--;
      end else begin
        evtReady_i = 1'b1;
      end
      if (evtRequest_o === 1'b1) lowLeft = 3;
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    lowLeft = 0;
    issueLog.delete();
    issueCyc.delete();
  endtask

  initial begin
    int n;
    // Reset state
    autoChan = 1'b0;
    evtReady_i = 1'b1;
    doReset();
    check("reset_evtRequest", 32'(evtRequest_o), 0);
    check("reset_grantId",    32'(grantId_o),    0);
    check("reset_pending",    32'(pending_o),    0);
    check("reset_overflow",   32'(overflow_o),   0);

    // 1: single event, issue two cycles after the request
    autoChan = 1'b1;
    req_i = 4'b0010;
    tick();
    check("t1_not_yet", 32'(evtRequest_o), 0);
    tick();
    check("t1_issue_t2", 32'(evtRequest_o), 1);
    check("t1_grant", 32'(grantId_o), 1);
    repeat (10) tick();
    check("t1_pending_clear", 32'(pending_o), 0);
    check("t1_issue_count", 32'(issueLog.size()), 1);

    // 2: all four at once, issued in index order with full handshakes between
    doReset();
    autoChan = 1'b1;
    req_i = 4'b1111;
    repeat (40) tick();
    check("t2_count", 32'(issueLog.size()), 4);
    for (int k = 0; k < 4; k++) begin
      n = (k < issueLog.size()) ? issueLog[k] : -1;
      check("t2_order", 32'(n), 32'(k));
    end
    for (int k = 1; k < 4; k++) begin
      n = (k < issueCyc.size()) ? issueCyc[k] - issueCyc[k-1] : -1;
      check("t2_gap", 32'(n), 6);
    end

    // 3: round-robin fairness, requester 0 every cycle, requester 2 once
    doReset();
    autoChan = 1'b1;
    req_i = 4'b0101;
    tick();
    repeat (19) begin
      req_i = 4'b0001;
      tick();
    end
    n = (issueLog.size() >= 2) ? issueLog[0] : -1;
    check("t3_first", 32'(n), 0);
    n = (issueLog.size() >= 2) ? issueLog[1] : -1;
`ifdef CDC_EVENT_SCHED_FIXED_PRIO_EN
    check("t3_second", 32'(n), 0);
`else
    check("t3_second", 32'(n), 2);
`endif

    // 4: saturation with ready held low, then drain
    doReset();
    autoChan = 1'b0;
    evtReady_i = 1'b0;
    ovf3Count = 0;
    repeat (16) begin
      req_i = 4'b1000;
      tick();
    end
    tick();
    check("t4_overflow_pulses", 32'(ovf3Count), 1);
    check("t4_pending", 32'(pending_o), 32'(4'b1000));
    autoChan = 1'b1;
    evtReady_i = 1'b1;
    issueLog.delete();
    repeat (120) tick();
    check("t4_issue_count", 32'(issueLog.size()), 15);
    check("t4_pending_clear", 32'(pending_o), 0);

    // 5: request and issue of the same requester in one cycle
    doReset();
    autoChan = 1'b0;
    evtReady_i = 1'b0;
    req_i = 4'b0010; tick();
    req_i = 4'b0010; tick();
    autoChan = 1'b1;
    evtReady_i = 1'b1;
    req_i = 4'b0010;
    tick();
    check("t5_issue", 32'(evtRequest_o), 1);
    check("t5_no_overflow", 32'(overflow_o[1]), 0);
    repeat (30) tick();
    check("t5_issue_count", 32'(issueLog.size()), 3);

    // 6: reset while waiting for ready to drop, with three events pending
    doReset();
    autoChan = 1'b0;
    evtReady_i = 1'b1;
    req_i = 4'b1111;
    tick();
    tick();
    tick();
    check("t6_pending_before", 32'(pending_o), 32'(4'b1110));
    doReset();
    check("t6_rst_evtRequest", 32'(evtRequest_o), 0);
    check("t6_rst_pending", 32'(pending_o), 0);
    check("t6_rst_grant", 32'(grantId_o), 0);
    repeat (8) tick();
    check("t6_no_issue", 32'(issueLog.size()), 0);

    // Randomized traffic with random channel behaviour and sporadic resets
    autoChan = 1'b0;
    for (int k = 0; k < 400; k++) begin
      req_i = 4'($urandom) & 4'($urandom);
      evtReady_i = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
